assoc_cache_fill: RTL and testbench
===================================

Name: assoc_cache_fill

Overview:
- Fill/response side of the 4-line fully associative cache: the lookup front end only reports hit/miss; this block owns the tag store, lines and fill engine.
- Accepts one 12-bit read request at a time and compares addr[11:5] against all valid tags.
- On a hit, it returns the word from the line.
- On a miss, it fetches the 8-word line from main memory, installs it in the round-robin victim way, then returns the word.
- Sits between the requester and the main-memory read port.

Parameters:
- TAG_W, 7, tag width = addr[11:5]
- NUM_LINES, 4, number of fully associative lines (power of 2)
- WORDS, 8, 32-bit words per line; word index = addr[4:2]
- DATA_W, 32, data word width

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_addr  in  12  byte address; [1:0] ignored
- req_ready  out  1  block can accept a request this cycle
- flush  in  1  invalidate all lines (acted on in IDLE only)
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  1 = served from cache, 0 = served after fill
- resp_data  out  DATA_W  requested word
- mem_rd_en  out  1  memory read request, held until accepted
- mem_rd_addr  out  12  word-aligned read address {tag, idx, 2'b00}
- mem_rd_valid  in  1  memory returns data this cycle
- mem_rd_data  in  DATA_W  returned word
- hit_count  out  8  wrapping hit counter
- miss_count  out  8  wrapping miss counter

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; state IDLE; all valid bits 0; victim pointer 0; counters 0.
  - Tag and data contents are don't-care.
  - Reset mid-fill aborts the fill: mem_rd_en is low the next cycle, nothing is installed, and a late mem_rd_valid is ignored.
- IDLE:
  - req_ready = !flush.
  - flush=1: clear all valid bits and the pointer; stay IDLE. flush wins over a simultaneous req_valid, which is not accepted.
  - req_valid && req_ready: latch req_addr; go LOOKUP.
- LOOKUP (1 cycle):
  - Compare the latched tag against every line with valid=1.
  - Hit: hit_count++; go RESP with resp_hit=1.
  - Miss: miss_count++; victim = pointer; clear valid[victim]; word counter = 0; go FILL.
  - More than one matching tag cannot occur by construction.
- FILL:
  - mem_rd_en=1 with mem_rd_addr = {tag, cnt[2:0], 2'b00}. Address is stable while en=1.
  - Only one read is outstanding at a time.
  - On a cycle with mem_rd_en && mem_rd_valid: write the word to data[victim][cnt] and increment cnt.
  - mem_rd_en is deasserted in the cycle after the beat with cnt==7.
  - Memory latency is arbitrary (≥1 cycle). mem_rd_valid while mem_rd_en=0 is ignored.
  - After the 8th word: tag[victim]=tag; valid[victim]=1; pointer = (pointer+1) mod NUM_LINES; go RESP with resp_hit=0.
- RESP (1 cycle):
  - resp_valid=1; resp_data = data[line][addr[4:2]].
  - On a miss this includes a word captured in the same fill.
  - Next state IDLE; req_ready returns to 1 the following cycle.
  - No backpressure on the response.
- Latency (request accepted at cycle T):
  - Hit: resp_valid at T+2.
  - Miss with memory returning 1 cycle after each en: resp_valid at T+18.
- Outside RESP, resp_valid=0, while resp_data/resp_hit hold their last value.
- Replacement order: lines fill 0,1,2,3 after reset/flush, then evict in FIFO order.
- Counters wrap 255→0.
- req_valid outside IDLE is ignored; the requester must hold it until req_ready.

Test Plan:
- Reset, then read 0x000 → miss. mem_rd_addr steps 0x000,0x004..0x01C; line 0 installed with tag 0. resp_hit=0, resp_data = mem[0x000]; miss_count=1.
- Then read 0x014 → resp_valid 2 cycles after acceptance, resp_hit=1, resp_data = mem[0x014], no mem_rd_en; hit_count=1.
- Miss tags 0,11,50,8 (0x000,0x160,0x640,0x100), then read 0xF00 (tag 120) → line 0 evicted. A following read 0x000 misses again; read 0x160 still hits.
- Memory stalls 3 cycles per beat → mem_rd_en and mem_rd_addr hold steady during each stall. All 8 words are captured correctly; total miss latency = 2 + 8×4 = 34 cycles.
- Reset asserted at beat 4 of a fill → mem_rd_en=0 next cycle; then read the same address → miss (no partial line hit).
- flush and req_valid both asserted in IDLE → request not accepted. The next request to a previously cached address misses; pointer restarts at line 0.

Source files
------------

// File: rtl/assoc_cache_fill_if.sv
// Request/response and memory-read bus of the associative cache fill block.
// The "slave" side is the cache; the "master" side is the requester plus main memory.
interface assoc_cache_fill_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic [11:0]       req_addr;
  logic              req_ready;
  logic              flush;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic              mem_rd_en;
  logic [11:0]       mem_rd_addr;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  req_valid, req_addr, flush, mem_rd_valid, mem_rd_data,
    output req_ready, resp_valid, resp_hit, resp_data, mem_rd_en, mem_rd_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_rd_valid, mem_rd_data,
    input  req_ready, resp_valid, resp_hit, resp_data, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/assoc_cache_fill.sv
// Fully associative cache fill engine: tag store, line data, round-robin
// replacement and one-outstanding-read line fill from main memory.
module assoc_cache_fill #(
  parameter int unsigned TAG_W     = 7,
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned WORDS     = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  assoc_cache_fill_if.slave cif,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count
);
  localparam int unsigned IDX_W  = $clog2(WORDS);
  localparam int unsigned LINE_W = $clog2(NUM_LINES);
  localparam int unsigned ADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

  state_t state, nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]  tags [NUM_LINES];
  logic [DATA_W-1:0] data [NUM_LINES][WORDS];
  logic [LINE_W-1:0] ptr;
  logic [LINE_W-1:0] victim;
  logic [IDX_W-1:0]  cnt;
  logic              resp_hit_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              hit;
  logic [LINE_W-1:0] hit_line;
  logic              beat;
  logic              last_beat;
  logic              unused_addr_lsbs;

  assign tag_q            = addr_q[ADDR_W-1:IDX_W];
  assign idx_q            = addr_q[IDX_W-1:0];
  assign beat             = (state == FILL) && cif.mem_rd_valid;
  assign last_beat        = beat && (cnt == IDX_W'(WORDS - 1));
  assign unused_addr_lsbs = ^cif.req_addr[1:0];

  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (valid[i] && (tags[i] == tag_q)) begin
        hit      = 1'b1;
        hit_line = LINE_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!cif.flush && cif.req_valid) nxt = LOOKUP;
      LOOKUP:  nxt = hit ? RESP : FILL;
      FILL:    if (last_beat) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    cif.req_ready   = (state == IDLE) && !cif.flush && !reset;
    cif.resp_valid  = (state == RESP);
    cif.resp_hit    = resp_hit_q;
    cif.resp_data   = resp_data_q;
    cif.mem_rd_en   = (state == FILL);
    cif.mem_rd_addr = {tag_q, cnt, 2'b00};
  end

  // The response word is registered as the FSM enters RESP; on a fill whose
  // requested word is the final beat it comes straight from the memory bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= '0;
      ptr         <= '0;
      victim      <= '0;
      cnt         <= '0;
      addr_q      <= '0;
      resp_hit_q  <= 1'b0;
      resp_data_q <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cif.flush) begin
            valid <= '0;
            ptr   <= '0;
          end else if (cif.req_valid) begin
            addr_q <= cif.req_addr[ADDR_W+1:2];
          end
        end
        LOOKUP: begin
          if (hit) begin
            hit_count   <= hit_count + 8'd1;
            resp_hit_q  <= 1'b1;
            resp_data_q <= data[hit_line][idx_q];
          end else begin
            miss_count  <= miss_count + 8'd1;
            victim      <= ptr;
            valid[ptr]  <= 1'b0;
            cnt         <= '0;
          end
        end
        FILL: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              valid[victim] <= 1'b1;
              ptr           <= ptr + 1'b1;
              resp_hit_q    <= 1'b0;
              resp_data_q   <= (idx_q == cnt) ? cif.mem_rd_data : data[victim][idx_q];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && beat) data[victim][cnt] <= cif.mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && last_beat) tags[victim] <= tag_q;
  end
endmodule

// File: tb/tb_assoc_cache_fill.sv
// Directed bench for assoc_cache_fill: hits, misses, FIFO eviction, memory
// stalls, reset mid-fill, flush priority and counter wrap.
module tb_assoc_cache_fill;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  assoc_cache_fill_if #(.DATA_W(32)) cif ();

  assoc_cache_fill #(
    .TAG_W(7),
    .NUM_LINES(4),
    .WORDS(8),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cif(cif),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  int unsigned lat_cfg = 1;
  int unsigned wait_n  = 0;
  bit          spur    = 1'b0;

  logic        r_hit;
  logic [31:0] r_data;
  int unsigned r_lat;
  int unsigned r_beats;
  bit          r_en_seen;
  bit          r_addr_ok;
  bit          r_stable_ok;

  function automatic logic [31:0] memval(input logic [11:0] a);
    return {20'hC0DE0, a};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory: valid appears lat_cfg cycles after the read request is first seen.
  initial begin
    cif.mem_rd_valid = 1'b0;
    cif.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (spur) begin
        cif.mem_rd_valid = 1'b1;
        cif.mem_rd_data  = 32'hDEAD_BEEF;
        wait_n           = 0;
      end else if (cif.mem_rd_en) begin
        if (wait_n == lat_cfg) begin
          cif.mem_rd_valid = 1'b1;
          cif.mem_rd_data  = memval(cif.mem_rd_addr);
          wait_n           = 0;
        end else begin
          cif.mem_rd_valid = 1'b0;
          wait_n           = wait_n + 1;
        end
      end else begin
        cif.mem_rd_valid = 1'b0;
        wait_n           = 0;
      end
    end
  end

  task automatic request(input logic [11:0] a);
    int unsigned n;
    logic [11:0] prev_addr;
    bit          prev_stall;
    r_lat       = 0;
    r_beats     = 0;
    r_en_seen   = 1'b0;
    r_addr_ok   = 1'b1;
    r_stable_ok = 1'b1;
    prev_stall  = 1'b0;
    prev_addr   = '0;
    cif.req_valid = 1'b1;
    cif.req_addr  = a;
    n = 0;
    while (!cif.req_ready && n < 20) begin
      tick();
      n = n + 1;
    end
    tick();
    cif.req_valid = 1'b0;
    r_lat = 1;
    while (!cif.resp_valid && r_lat < 100) begin
      if (cif.mem_rd_en) begin
        r_en_seen = 1'b1;
        if (prev_stall && (cif.mem_rd_addr !== prev_addr)) r_stable_ok = 1'b0;
        if (cif.mem_rd_valid) begin
          if (cif.mem_rd_addr !== {a[11:5], 3'(r_beats), 2'b00}) r_addr_ok = 1'b0;
          r_beats    = r_beats + 1;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
        end
        prev_addr = cif.mem_rd_addr;
      end
      tick();
      r_lat = r_lat + 1;
    end
    r_hit  = cif.resp_hit;
    r_data = cif.resp_data;
  endtask

  task automatic expect_resp(input string tag, input logic [11:0] a, input bit hit,
                             input int unsigned lat);
    request(a);
    chk({tag, ".hit"}, 32'(r_hit), 32'(hit));
    chk({tag, ".data"}, r_data, memval(a));
    chk({tag, ".lat"}, r_lat, lat);
    if (hit) begin
      chk({tag, ".no_mem_rd"}, 32'(r_en_seen), 32'd0);
    end else begin
      chk({tag, ".beats"}, r_beats, 32'd8);
      chk({tag, ".beat_addr"}, 32'(r_addr_ok), 32'd1);
      chk({tag, ".addr_stable"}, 32'(r_stable_ok), 32'd1);
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned beats;
    bit          seen;

    reset         = 1'b1;
    cif.req_valid = 1'b0;
    cif.req_addr  = '0;
    cif.flush     = 1'b0;
    repeat (3) tick();
    chk("rst.ready_during_reset", 32'(cif.req_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst.ready", 32'(cif.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(cif.resp_valid), 32'd0);
    chk("rst.resp_hit", 32'(cif.resp_hit), 32'd0);
    chk("rst.resp_data", cif.resp_data, 32'd0);
    chk("rst.mem_rd_en", 32'(cif.mem_rd_en), 32'd0);
    chk("rst.mem_rd_addr", 32'(cif.mem_rd_addr), 32'd0);
    chk("rst.hit_count", 32'(hit_count), 32'd0);
    chk("rst.miss_count", 32'(miss_count), 32'd0);

    // lines fill 0..3, then 0xF00 evicts line 0 (tag 0)
    expect_resp("m000", 12'h000, 1'b0, 18);
    chk("m000.miss_count", 32'(miss_count), 32'd1);
    expect_resp("h014", 12'h014, 1'b1, 2);
    chk("h014.hit_count", 32'(hit_count), 32'd1);
    expect_resp("m160", 12'h160, 1'b0, 18);
    expect_resp("m640", 12'h640, 1'b0, 18);
    expect_resp("m11C", 12'h11C, 1'b0, 18);
    expect_resp("mF00", 12'hF00, 1'b0, 18);
    chk("evict.miss_count", 32'(miss_count), 32'd5);
    expect_resp("h160", 12'h160, 1'b1, 2);
    expect_resp("re000", 12'h000, 1'b0, 18);
    expect_resp("h640", 12'h640, 1'b1, 2);
    expect_resp("h01C", 12'h01C, 1'b1, 2);
    chk("evict.hit_count", 32'(hit_count), 32'd4);
    chk("evict.miss_count2", 32'(miss_count), 32'd6);

    // three stall cycles per beat
    lat_cfg = 3;
    expect_resp("stall2A8", 12'h2A8, 1'b0, 34);
    lat_cfg = 1;
    expect_resp("h2BC", 12'h2BC, 1'b1, 2);
    expect_resp("h2A0", 12'h2A0, 1'b1, 2);
    expect_resp("m640b", 12'h640, 1'b0, 18);
    chk("stall.hit_count", 32'(hit_count), 32'd6);
    chk("stall.miss_count", 32'(miss_count), 32'd8);

    // reset during the 4th beat of a fill
    cif.req_valid = 1'b1;
    cif.req_addr  = 12'h7E4;
    n = 0;
    while (!cif.req_ready && n < 20) begin
      tick();
      n = n + 1;
    end
    tick();
    cif.req_valid = 1'b0;
    beats = 0;
    n = 0;
    while (beats < 4 && n < 100) begin
      tick();
      n = n + 1;
      if (cif.mem_rd_en && cif.mem_rd_valid) beats = beats + 1;
    end
    chk("rstfill.beats_reached", beats, 32'd4);
    reset = 1'b1;
    tick();
    chk("rstfill.mem_rd_en", 32'(cif.mem_rd_en), 32'd0);
    chk("rstfill.hit_count", 32'(hit_count), 32'd0);
    chk("rstfill.miss_count", 32'(miss_count), 32'd0);
    reset = 1'b0;
    spur  = 1'b1;
    seen  = 1'b0;
    repeat (3) begin
      tick();
      if (cif.mem_rd_en || cif.resp_valid) seen = 1'b1;
    end
    spur = 1'b0;
    tick();
    chk("rstfill.late_valid_ignored", 32'(seen), 32'd0);
    chk("rstfill.ready", 32'(cif.req_ready), 32'd1);
    expect_resp("rstfill.re7E4", 12'h7E4, 1'b0, 18);
    chk("rstfill.miss_count2", 32'(miss_count), 32'd1);

    // flush beats a simultaneous request and drops cached lines
    tick();
    cif.flush     = 1'b1;
    cif.req_valid = 1'b1;
    cif.req_addr  = 12'h7E4;
    #1;
    chk("flush.ready", 32'(cif.req_ready), 32'd0);
    tick();
    cif.flush     = 1'b0;
    cif.req_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (cif.resp_valid || cif.mem_rd_en) seen = 1'b1;
      tick();
    end
    chk("flush.not_accepted", 32'(seen), 32'd0);
    expect_resp("flush.m7E4", 12'h7E4, 1'b0, 18);
    chk("flush.miss_count", 32'(miss_count), 32'd2);
    chk("flush.hit_count", 32'(hit_count), 32'd0);

    // hit counter wraps 255 -> 0
    repeat (255) request(12'h7E0);
    chk("wrap.hit_255", 32'(hit_count), 32'd255);
    expect_resp("wrap.last", 12'h7FC, 1'b1, 2);
    chk("wrap.hit_0", 32'(hit_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
